// File: rtl/md_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MADDU = 3'd7
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int MD_WIDTH_DEF       = 32;
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_latency_ctr.sv
// Loadable down-counter timing a multi-cycle operation; done flags terminal count.
module md_latency_ctr #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// MADD/MADDU accumulate only when MD_UNIT_MADD_EN is defined; otherwise no-ops.
//
//   state   | meaning
//   MD_IDLE | accepts start; MTHI/MTLO write immediately
//   MD_RUN  | result pending in p_hi/p_lo, counting down to commit
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = MD_WIDTH_DEF,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    md_state_e          state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   p_hi_q, p_hi_d, p_lo_q, p_lo_d;
    logic               ctr_load, ctr_dec, ctr_done;
    logic [CW-1:0]      ctr_load_val;
    md_op_e             op_e;

    logic [2*WIDTH-1:0] prod_s, prod_u;
    logic               div_sgn;
    logic [WIDTH-1:0]   div_num, div_den, div_q, div_r, quot, rem;

    assign op_e = md_op_e'(op);

    assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide runs on magnitudes; most-negative / -1 falls out as lo=a, hi=0.
    assign div_sgn = (op_e == MD_DIV);
    assign div_num = (div_sgn && a[WIDTH-1]) ? -a : a;
    assign div_den = (div_sgn && b[WIDTH-1]) ? -b : b;
    assign div_q   = div_num / div_den;
    assign div_r   = div_num % div_den;
    assign quot    = (div_sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -div_q : div_q;
    assign rem     = (div_sgn && a[WIDTH-1]) ? -div_r : div_r;

    md_latency_ctr #(.CW(CW)) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_load_val),
        .dec      (ctr_dec),
        .done     (ctr_done)
    );

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        p_hi_d       = p_hi_q;
        p_lo_d       = p_lo_q;
        ctr_load     = 1'b0;
        ctr_load_val = MULT_LOAD;
        ctr_dec      = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (op_e)
                        MD_MULT: begin
                            {p_hi_d, p_lo_d} = prod_s;
                            ctr_load         = 1'b1;
                            state_d          = MD_RUN;
                        end
                        MD_MULTU: begin
                            {p_hi_d, p_lo_d} = prod_u;
                            ctr_load         = 1'b1;
                            state_d          = MD_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Divide by zero still takes the full latency but commits the old HI/LO.
                            if (b == '0) begin
                                p_hi_d = hi_q;
                                p_lo_d = lo_q;
                            end else begin
                                p_hi_d = rem;
                                p_lo_d = quot;
                            end
                            ctr_load     = 1'b1;
                            ctr_load_val = DIV_LOAD;
                            state_d      = MD_RUN;
                        end
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        MD_MADD, MD_MADDU: begin
`ifdef MD_UNIT_MADD_EN
                            {p_hi_d, p_lo_d} = {hi_q, lo_q} + ((op_e == MD_MADD) ? prod_s : prod_u);
                            ctr_load         = 1'b1;
                            state_d          = MD_RUN;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            MD_RUN: begin
                if (ctr_done) begin
                    hi_d    = p_hi_q;
                    lo_d    = p_lo_q;
                    state_d = MD_IDLE;
                end else begin
                    ctr_dec = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
        end
    end

    assign busy = (state_q == MD_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: multi-cycle results are queued at issue and checked when busy falls.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t sb_q[$];

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and compares hi/lo when busy falls.
    initial begin
        int  run_len;
        bit  prev_busy;
        exp_t e;
        run_len   = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                run_len   = 0;
                prev_busy = 1'b0;
            end else begin
                if (busy) begin
                    run_len++;
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 64'(sb_q.size()), 64'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                        chk({e.name, "_busy_len"}, 64'(run_len), 64'(e.len));
                    end
                    run_len = 0;
                end
                prev_busy = busy;
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
    endtask

    task automatic expect_run(input string nm, input logic [31:0] eh, input logic [31:0] el, input int n);
        exp_t e;
        e.name = nm;
        e.hi   = eh;
        e.lo   = el;
        e.len  = n;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({nm, "_timeout"}, 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] eh, input logic [31:0] el,
                          input int n);
        expect_run(nm, eh, el, n);
        issue(o, av, bv);
        wait_idle(nm);
    endtask

    initial begin
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // MTHI then MTLO on consecutive strobes
        @(posedge clk);
        #1;
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        @(posedge clk);
        #1;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_busy", 64'(busy), 64'd0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
        chk("mtlo_hi", 64'(hi), 64'h1234_5678);
        chk("mtlo_busy", 64'(busy), 64'd0);

        // Reset in the middle of a DIV
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rstrun_busy", 64'(busy), 64'd0);
        chk("rstrun_hi", 64'(hi), 64'd0);
        chk("rstrun_lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("postrst_busy", 64'(busy), 64'd0);
        chk("postrst_hi", 64'(hi), 64'd0);
        chk("postrst_lo", 64'(lo), 64'd0);

        run_op("mult",    3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        run_op("multu",   3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        run_op("div_negb",3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
        run_op("divu_z",  3'd3, 32'd55, 32'd0, 32'd0, 32'h8000_0000, 10);
        run_op("divu",    3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        run_op("div_sz",  3'd2, 32'hFFFF_FFF0, 32'd0, 32'd2, 32'd14, 10);

        // A second start while busy must be ignored
        expect_run("mult_2nd", 32'd1, 32'd0, 5);
        issue(3'd0, 32'h0001_0000, 32'h0001_0000);
        @(posedge clk);
        #1;
        start = 1'b1; op = 3'd2; a = 32'd5; b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle("mult_2nd");

        // Accumulate from hi=0, lo=0xFFFFFFFF
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'hFFFF_FFFF, 32'd0);
`ifdef MD_UNIT_MADD_EN
        run_op("maddu", 3'd7, 32'd1, 32'd1, 32'd1, 32'd0, 5);
        run_op("madd",  3'd6, 32'hFFFF_FFFF, 32'd3, 32'd0, 32'hFFFF_FFFD, 5);
`else
        issue(3'd7, 32'd1, 32'd1);
        chk("maddu_off_busy", 64'(busy), 64'd0);
        issue(3'd6, 32'hFFFF_FFFF, 32'd3);
        chk("madd_off_busy", 64'(busy), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("madd_off_busy2", 64'(busy), 64'd0);
        chk("madd_off_hi", 64'(hi), 64'd0);
        chk("madd_off_lo", 64'(lo), 64'hFFFF_FFFF);
`endif

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Parametrised multi-cycle multiply/divide unit with HI/LO registers. It is the next-generation datapath block for the pipelined MIPS core. The block sits in the EX stage beside the ALU. The hazard unit stalls the pipeline using start|busy, so mult/div/madd latency is modelled cycle-accurately instead of completing in one cycle.

Parameters:
WIDTH, 32, operand and HI/LO width
MULT_CYCLES, 5, busy cycles for MULT/MULTU/MADD/MADDU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  one-cycle request strobe; sampled at clk rising edge
op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt)
busy  output  1  high while a multi-cycle operation is in flight
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, counter=0, pending result=0. State=IDLE.
- FSM has two states, IDLE and RUN.
- IDLE + start + op in {0,1,2,3,6,7}:
  - Compute the result combinationally from a and b, and latch it into pending {p_hi,p_lo} at the edge.
  - Load counter with N-1, where N = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from the next cycle.
- RUN: decrement counter each edge. At the edge where counter==0, commit {hi,lo}={p_hi,p_lo}, go to IDLE, busy=0.
  - busy is therefore high for exactly N cycles.
  - New hi/lo values are visible the cycle busy falls.
- IDLE + start + op 4/5 (MTHI/MTLO): hi<=a or lo<=a at that edge. No busy. Latency 1.
- start while busy=1: ignored completely (no state change). The hazard unit guarantees this does not happen; verification checks it is harmless.
- MULT: signed WIDTHxWIDTH -> 2*WIDTH product. {hi,lo}=product.
- MULTU: unsigned product, same split.
- DIV/DIVU: lo=quotient, hi=remainder.
  - Signed division truncates toward zero. Remainder takes the sign of the dividend.
  - Signed overflow (a=most-negative, b=-1): lo=a, hi=0.
- Divide by zero (b==0), DIV or DIVU: operation still runs DIV_CYCLES with busy=1, but hi/lo are unchanged at commit.
- MADD/MADDU: see Optional Feature.
- Operands are sampled only at the start edge. Changes to a/b during RUN have no effect.
- Reset asserted mid-RUN: operation is aborted immediately, all outputs return to reset values, and no commit occurs.
- MULT_CYCLES or DIV_CYCLES = 1: busy is high for exactly one cycle and commit happens at the following edge.

Optional Feature:
- Macro MD_UNIT_MADD_EN.
- Defined: op 6 (MADD) computes {hi,lo} + signed(a*b), and op 7 (MADDU) computes {hi,lo} + unsigned(a*b), both modulo 2^(2*WIDTH).
  - The accumulate base is the committed {hi,lo} at the start edge.
  - Latency is MULT_CYCLES.
- Not defined: ops 6 and 7 are no-ops. No busy, hi/lo unchanged.

Decomposition:
- Package md_pkg:
  - op encodings MD_MULT..MD_MADDU
  - state encodings MD_IDLE/MD_RUN
  - default latency constants
- One sub-module, md_latency_ctr: loadable down-counter with a done flag, width $clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
- Arithmetic stays inline in md_unit.

Test Plan:
- Reset: assert reset mid-RUN of a DIV -> busy, hi and lo all read 0 immediately (asynchronous). No commit after reset is released.
- MULT a=0xFFFFFFFE(-2), b=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9(-7), b=2 -> busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0. DIVU with b=0 -> hi/lo keep their prior values and busy still lasts 10 cycles.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> hi and lo update one edge after each strobe, busy stays 0. Then start MULT with busy=1 and drive a second start -> the second start is ignored and the result matches the first MULT only.
- With MD_UNIT_MADD_EN defined: hi=0, lo=0xFFFFFFFF, then MADDU a=1, b=1 -> hi=1, lo=0 after 5 cycles. Without the macro: same stimulus -> busy stays 0 and hi/lo are unchanged.
